cdc_handshake_tx: RTL

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_handshake_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
// Source side of a four-phase req/ack handshake that carries one WIDTH-bit
// word per transfer into an unrelated clock domain. The word is held
// constant on data_o for the whole handshake. The far side may therefore
// sample it whenever its synchronized view of req_o is high.
//
// Ports
//   clk_i      : sole clock, rising edge
//   rst_ni     : asynchronous reset, active low
//   valid_i    : producer offers data_i
//   data_i     : word to transfer
//   ready_o    : block is idle and can take a word (state only)
//   req_o      : four-phase request level, straight from a flop
//   data_o     : word presented to the far domain, straight from a flop
//   ack_i      : four-phase acknowledge, asynchronous to clk_i
//   done_o     : one-cycle pulse when a handshake completes
//   err_o      : sticky flag, handshake exceeded TIMEOUT cycles
//   err_clr_i  : clears err_o (a simultaneous set wins)
//
// Parameters
//   WIDTH      : data width
//   SYNC_REGS  : acknowledge synchronizer depth, must be >= 2
//   TIMEOUT    : cycles allowed per handshake, 0 disables the check
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
  parameter int WIDTH     = 32,
  parameter int SYNC_REGS = 2,
  parameter int TIMEOUT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  // The counter compares against TIMEOUT-1 so that err_o rises exactly
  // TIMEOUT cycles after req_o rises.
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);
  localparam bit          C_TO_EN   = (TIMEOUT != 0);

  state_e           r_state;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic             r_err;
  logic [15:0]      r_cnt;

  // Acknowledge synchronizer; the attributes keep the stages together and
  // stop them being folded into an SRL.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_REGS-1:0] r_ack_sync;

  logic w_ack_s;
  logic w_accept;
  logic w_busy;
  logic w_to_hit;

  assign w_ack_s  = r_ack_sync[SYNC_REGS-1];
  assign ready_o  = (r_state == ST_IDLE);
  // An ack still high in IDLE is a far-side protocol violation. Hold off the
  // next word until it drops, so the new request is not acknowledged by a
  // stale level.
  assign w_accept = valid_i && ready_o && !w_ack_s;
  assign w_busy   = (r_state == ST_REQ) || (r_state == ST_REL);
  assign w_to_hit = C_TO_EN && w_busy && (r_cnt == C_TO_LAST);

  assign req_o  = r_req;
  assign data_o = r_data;
  assign done_o = r_done;
  assign err_o  = r_err;

  // Shift ack_i through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_REGS-2:0], ack_i};
    end
  end

  // Handshake FSM with its registered outputs and the per-handshake counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (w_busy && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= data_i;
            r_req   <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= ST_REL;
          end
        end
        ST_REL: begin
          if (!w_ack_s) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; setting has priority over clearing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_to_hit) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

endmodule
